// File: rtl/lstm_pkg.sv
// Shared constants and types for the LSTM cell sequencer.
// Register map, register count and controller state encoding.
package lstm_pkg;

  localparam int NUM_WREGS = 13;

  localparam logic [3:0] ADDR_WI   = 4'd0;
  localparam logic [3:0] ADDR_WF   = 4'd1;
  localparam logic [3:0] ADDR_WK   = 4'd2;
  localparam logic [3:0] ADDR_WO   = 4'd3;
  localparam logic [3:0] ADDR_UI   = 4'd4;
  localparam logic [3:0] ADDR_UF   = 4'd5;
  localparam logic [3:0] ADDR_UK   = 4'd6;
  localparam logic [3:0] ADDR_UO   = 4'd7;
  localparam logic [3:0] ADDR_VO   = 4'd8;
  localparam logic [3:0] ADDR_BI   = 4'd9;
  localparam logic [3:0] ADDR_BF   = 4'd10;
  localparam logic [3:0] ADDR_BK   = 4'd11;
  localparam logic [3:0] ADDR_BO   = 4'd12;
  localparam logic [3:0] ADDR_CTRL = 4'd13;
  localparam logic [3:0] ADDR_RSVD = 4'd14;
  localparam logic [3:0] ADDR_CLR  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/lstm_wreg_file.sv
// Weight/bias register file with ctrl bit and clear decode.
// Writes land only while the sequencer is idle.
module lstm_wreg_file
  import lstm_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         idle,
  input  logic         cfg_we,
  input  logic [3:0]   cfg_addr,
  input  logic [7:0]   cfg_wdata,
  output logic         cfg_err,
  output logic         clr,
  output logic         cell_cip,
  output logic [103:0] cell_w
);

  logic [NUM_WREGS-1:0][7:0] w_q, w_d;
  logic                      cip_q, cip_d;
  logic                      wr_ok;

  assign wr_ok    = cfg_we & idle;
  assign cfg_err  = cfg_we & ~idle;
  assign clr      = wr_ok & (cfg_addr == ADDR_CLR);
  assign cell_cip = cip_q;
  assign cell_w   = w_q;

  // Decode an accepted write into the weight bytes or the ctrl bit.
  always_comb begin
    w_d   = w_q;
    cip_d = cip_q;
    if (wr_ok) begin
      for (int k = 0; k < NUM_WREGS; k++) begin
        if (cfg_addr == 4'(k)) w_d[k] = cfg_wdata;
      end
      if (cfg_addr == ADDR_CTRL) cip_d = cfg_wdata[0];
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q   <= '0;
      cip_q <= 1'b0;
    end else begin
      w_q   <= w_d;
      cip_q <= cip_d;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// LSTM cell sequencer: feeds one sample per step, holds cell
// inputs for CELL_LAT cycles, captures and recirculates h/c.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int CELL_LAT = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic             cfg_err,
  output logic             cell_en,
  output logic             cell_cip,
  output logic [7:0]       cell_in,
  output logic [7:0]       cell_ci,
  output logic [7:0]       cell_prevh,
  output logic [103:0]     cell_w,
  input  logic [7:0]       cell_cout,
  input  logic [7:0]       cell_hout,
  input  logic             cell_of,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_h,
  output logic [7:0]       out_c,
  output logic             out_last,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] step_cnt
);

  localparam logic [3:0] LAT_INIT = 4'(CELL_LAT - 1);

  seq_state_e       state_q, state_d;
  logic [7:0]       cell_in_q, cell_in_d;
  logic             last_q, last_d;
  logic [3:0]       lat_q, lat_d;
  logic [7:0]       h_q, h_d;
  logic [7:0]       c_q, c_d;
  logic [7:0]       out_h_q, out_h_d;
  logic [7:0]       out_c_q, out_c_d;
  logic             out_last_q, out_last_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             idle;
  logic             clr;

  assign idle       = (state_q == IDLE);
  assign in_ready   = idle;
  assign cell_en    = (state_q == RUN);
  assign out_valid  = (state_q == OUT);
  assign cell_in    = cell_in_q;
  assign cell_ci    = c_q;
  assign cell_prevh = h_q;
  assign out_h      = out_h_q;
  assign out_c      = out_c_q;
  assign out_last   = out_last_q;
  assign ovf_sticky = ovf_q;
  assign step_cnt   = step_q;

  lstm_wreg_file u_wreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .idle      (idle),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .clr       (clr),
    .cell_cip  (cell_cip),
    .cell_w    (cell_w)
  );

  // Step sequencing: accept, hold for latency, capture, emit.
  always_comb begin
    state_d    = state_q;
    cell_in_d  = cell_in_q;
    last_d     = last_q;
    lat_d      = lat_q;
    h_d        = h_q;
    c_d        = c_q;
    out_h_d    = out_h_q;
    out_c_d    = out_c_q;
    out_last_d = out_last_q;
    ovf_d      = ovf_q;
    step_d     = step_q;
    if (clr) begin
      h_d    = '0;
      c_d    = '0;
      step_d = '0;
      ovf_d  = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cell_in_d = in_data;
          last_d    = in_last;
          lat_d     = LAT_INIT;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (lat_q == 4'd0) begin
          out_h_d    = cell_hout;
          out_c_d    = cell_cout;
          out_last_d = last_q;
          ovf_d      = ovf_q | cell_of;
          h_d        = cell_hout;
          c_d        = cell_cout;
          step_d     = step_q + 1'b1;
          state_d    = OUT;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (out_last_q) begin
            h_d    = '0;
            c_d    = '0;
            step_d = '0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cell_in_q  <= '0;
      last_q     <= 1'b0;
      lat_q      <= '0;
      h_q        <= '0;
      c_q        <= '0;
      out_h_q    <= '0;
      out_c_q    <= '0;
      out_last_q <= 1'b0;
      ovf_q      <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      cell_in_q  <= cell_in_d;
      last_q     <= last_d;
      lat_q      <= lat_d;
      h_q        <= h_d;
      c_q        <= c_d;
      out_h_q    <= out_h_d;
      out_c_q    <= out_c_d;
      out_last_q <= out_last_d;
      ovf_q      <= ovf_d;
      step_q     <= step_d;
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Self-checking bench for lstm_seq_ctrl with a reference model
// of weights, recurrent state, step count and overflow flag.
module tb_lstm_seq_ctrl;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         in_last = 1'b0;
  logic         cfg_we = 1'b0;
  logic [3:0]   cfg_addr = '0;
  logic [7:0]   cfg_wdata = '0;
  logic         cfg_err;
  logic         cell_en;
  logic         cell_cip;
  logic [7:0]   cell_in;
  logic [7:0]   cell_ci;
  logic [7:0]   cell_prevh;
  logic [103:0] cell_w;
  logic [7:0]   cell_cout = '0;
  logic [7:0]   cell_hout = '0;
  logic         cell_of = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_h;
  logic [7:0]   out_c;
  logic         out_last;
  logic         ovf_sticky;
  logic [7:0]   step_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] mw [13];
  logic       mcip;
  logic [7:0] mh, mc;
  int         mstep;
  logic       movf;

  lstm_seq_ctrl #(.CELL_LAT(LAT), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_err    (cfg_err),
    .cell_en    (cell_en),
    .cell_cip   (cell_cip),
    .cell_in    (cell_in),
    .cell_ci    (cell_ci),
    .cell_prevh (cell_prevh),
    .cell_w     (cell_w),
    .cell_cout  (cell_cout),
    .cell_hout  (cell_hout),
    .cell_of    (cell_of),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_h      (out_h),
    .out_c      (out_c),
    .out_last   (out_last),
    .ovf_sticky (ovf_sticky),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] wflat();
    logic [103:0] f;
    for (int k = 0; k < 13; k++) f[k*8 +: 8] = mw[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 13; k++) mw[k] = 8'h00;
    mcip = 1'b0; mh = 8'h00; mc = 8'h00; mstep = 0; movf = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    #1;
    chk("cfg_err_idle", 128'(cfg_err), 128'(0));
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a < 4'd13) mw[a] = d;
    else if (a == 4'd13) mcip = d[0];
    else if (a == 4'd15) begin
      mh = 8'h00; mc = 8'h00; mstep = 0; movf = 1'b0;
    end
    chk("wr_cell_w", 128'(cell_w), 128'(wflat()));
    chk("wr_cip", 128'(cell_cip), 128'(mcip));
    chk("wr_ovf", 128'(ovf_sticky), 128'(movf));
    chk("wr_step", 128'(step_cnt), 128'(mstep[7:0]));
    chk("wr_ci", 128'(cell_ci), 128'(mc));
  endtask

  task automatic step(input logic [7:0] d, input logic lst,
                      input logic [7:0] ho, input logic [7:0] co,
                      input logic of, input int hold,
                      input logic bad_cfg, input logic co_wr);
    int n;
    int wa;
    logic [7:0] wd;
    chk("in_ready_idle", 128'(in_ready), 128'(1));
    if (co_wr) begin
      wa = $urandom_range(0, 12);
      wd = 8'($urandom);
      cfg_we = 1'b1; cfg_addr = 4'(wa); cfg_wdata = wd;
      mw[wa] = wd;
    end
    in_valid = 1'b1; in_data = d; in_last = lst;
    cell_hout = ho; cell_cout = co; cell_of = of;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    n = 0;
    while (cell_en === 1'b1 && n < 20) begin
      if (n == 0) begin
        chk("run_cell_in", 128'(cell_in), 128'(d));
        chk("run_cell_ci", 128'(cell_ci), 128'(mc));
        chk("run_prevh", 128'(cell_prevh), 128'(mh));
        chk("run_cell_w", 128'(cell_w), 128'(wflat()));
        chk("run_cip", 128'(cell_cip), 128'(mcip));
        chk("run_in_ready", 128'(in_ready), 128'(0));
        chk("run_out_valid", 128'(out_valid), 128'(0));
        if (bad_cfg) begin
          wa = $urandom_range(0, 12);
          cfg_we = 1'b1; cfg_addr = 4'(wa); cfg_wdata = ~mw[wa];
          #1;
          chk("cfg_err_run", 128'(cfg_err), 128'(1));
        end
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      #1;
      chk("cfg_err_low", 128'(cfg_err), 128'(0));
      n++;
    end
    chk("cell_en_cycles", 128'(n), 128'(LAT));
    mh = ho; mc = co; mstep = (mstep + 1) % 256; movf = movf | of;
    chk("out_valid", 128'(out_valid), 128'(1));
    chk("out_h", 128'(out_h), 128'(ho));
    chk("out_c", 128'(out_c), 128'(co));
    chk("out_last", 128'(out_last), 128'(lst));
    chk("step_cnt", 128'(step_cnt), 128'(mstep[7:0]));
    chk("ovf_sticky", 128'(ovf_sticky), 128'(movf));
    chk("out_cell_w", 128'(cell_w), 128'(wflat()));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = ~d;
      cell_hout = 8'($urandom); cell_cout = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_out_h", 128'(out_h), 128'(ho));
      chk("hold_out_c", 128'(out_c), 128'(co));
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_cell_en", 128'(cell_en), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (lst) begin
      mh = 8'h00; mc = 8'h00; mstep = 0;
    end
    chk("post_valid", 128'(out_valid), 128'(0));
    chk("post_in_ready", 128'(in_ready), 128'(1));
    chk("post_step", 128'(step_cnt), 128'(mstep[7:0]));
    chk("post_ci", 128'(cell_ci), 128'(mc));
    chk("post_prevh", 128'(cell_prevh), 128'(mh));
  endtask

  initial begin
    int seen;
    logic [3:0] ra;
    model_reset();
    // Reset state
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_cell_en", 128'(cell_en), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_cell_w", 128'(cell_w), 128'(0));
    chk("rst_step", 128'(step_cnt), 128'(0));
    chk("rst_ovf", 128'(ovf_sticky), 128'(0));
    chk("rst_cfg_err", 128'(cfg_err), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte placement of first and last weight
    wr(4'd0, 8'h11);
    wr(4'd12, 8'h7F);
    chk("w0_byte", 128'(cell_w[7:0]), 128'(8'h11));
    chk("w12_byte", 128'(cell_w[103:96]), 128'(8'h7F));

    // Fixed cell response, then recurrence into the next step
    step(8'h05, 1'b0, 8'h30, 8'h40, 1'b0, 0, 1'b0, 1'b0);
    chk("rec_prevh", 128'(cell_prevh), 128'(8'h30));
    chk("rec_ci", 128'(cell_ci), 128'(8'h40));
    step(8'h06, 1'b1, 8'h31, 8'h41, 1'b0, 0, 1'b0, 1'b0);

    // Three-sample sequence, counter wraps to 0 after last
    step(8'hA1, 1'b0, 8'h12, 8'h34, 1'b0, 0, 1'b0, 1'b0);
    step(8'hA2, 1'b0, 8'h56, 8'h78, 1'b0, 0, 1'b0, 1'b0);
    step(8'hA3, 1'b1, 8'h9A, 8'hBC, 1'b0, 0, 1'b0, 1'b0);
    chk("seq_end_step", 128'(step_cnt), 128'(0));
    chk("seq_end_h", 128'(cell_prevh), 128'(0));

    // Back-pressure for 5 cycles
    step(8'h3C, 1'b0, 8'hC3, 8'h5A, 1'b0, 5, 1'b0, 1'b0);

    // Rejected write during RUN plus overflow capture
    step(8'h77, 1'b0, 8'h01, 8'h02, 1'b1, 0, 1'b1, 1'b0);
    step(8'h78, 1'b0, 8'h03, 8'h04, 1'b0, 1, 1'b0, 1'b0);
    chk("ovf_held", 128'(ovf_sticky), 128'(1));
    wr(4'd15, 8'hFF);
    chk("ovf_cleared", 128'(ovf_sticky), 128'(0));
    wr(4'd13, 8'h01);
    wr(4'd14, 8'hAA);

    // Write on the same edge as the handshake
    step(8'h10, 1'b0, 8'h20, 8'h30, 1'b0, 0, 1'b0, 1'b1);

    // Randomised mix of writes and steps
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ra = 4'($urandom_range(0, 15));
        wr(ra, 8'($urandom));
      end
      step(8'($urandom), 1'($urandom_range(0, 3) == 0),
           8'($urandom), 8'($urandom),
           1'($urandom_range(0, 7) == 0),
           $urandom_range(0, 3),
           1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0));
    end

    // Async reset in the 2nd RUN cycle
    in_valid = 1'b1; in_data = 8'h99; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_cell_en", 128'(cell_en), 128'(1));
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_cell_en", 128'(cell_en), 128'(0));
    chk("arst_out_h", 128'(out_h), 128'(0));
    chk("arst_step", 128'(step_cnt), 128'(0));
    chk("arst_cell_w", 128'(cell_w), 128'(0));
    chk("arst_ci", 128'(cell_ci), 128'(0));
    chk("arst_cell_in", 128'(cell_in), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    out_ready = 1'b0;
    chk("arst_no_valid", 128'(seen), 128'(0));
    step(8'h42, 1'b1, 8'h24, 8'h18, 1'b0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
- Sequencer on the driving side of the LSTM cell datapath. Holds the weight/bias register file and accepts a stream of 8-bit input samples.
- For each sample it presents In/Ci/PrevH and all weights to the cell and holds them stable for the cell latency. It then captures Cout/Hout/Of and feeds Cout/Hout back as Ci/PrevH for the next timestep.
- Results are emitted on a valid/ready output stream. Recurrent state is cleared at end of sequence.

Parameters:
- CELL_LAT, 2, cycles the cell inputs are held with cell_en=1 before outputs are sampled; legal range 1..15.
- CNT_W, 8, width of the per-sequence step counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  controller can accept a sample
- in_data  in  8  input sample x_t
- in_last  in  1  sample is the last of its sequence
- cfg_we  in  1  register-file write strobe
- cfg_addr  in  4  register address (map below)
- cfg_wdata  in  8  write data
- cfg_err  out  1  one-cycle pulse: write rejected (not IDLE)
- cell_en  out  1  enable to cell sigmoid ROMs
- cell_cip  out  1  carry-in to cell adder chain
- cell_in  out  8  x_t to cell
- cell_ci  out  8  previous cell state
- cell_prevh  out  8  previous hidden output
- cell_w  out  104  weights; byte k = register k, for k = 0..12
- cell_cout  in  8  cell state from cell
- cell_hout  in  8  hidden output from cell
- cell_of  in  1  cell overflow
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_h  out  8  captured Hout
- out_c  out  8  captured Cout
- out_last  out  1  result ends a sequence
- ovf_sticky  out  1  set by any captured cell_of=1
- step_cnt  out  CNT_W  steps completed in current sequence

Behaviour:
- Register map:
  - 0 Wi, 1 Wf, 2 Wk, 3 Wo
  - 4 Ui, 5 Uf, 6 Uk, 7 Uo
  - 8 Vo, 9 Bi, 10 Bf, 11 Bk, 12 Bo
  - 13 ctrl: bit0 drives cell_cip
  - 14 reserved: write ignored, no error
  - 15 clear command: data ignored; zeroes h_state, c_state, step_cnt and ovf_sticky
- Reset values: all registers, h_state, c_state, out_* and step_cnt = 0; ovf_sticky=0, cell_en=0, cfg_err=0, state=IDLE, in_ready=1.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - in_ready=1.
  - On the edge with in_valid&in_ready: latch in_data to cell_in and in_last to last_q, load lat_cnt=CELL_LAT-1, go to RUN.
  - cfg writes are accepted only in IDLE. If cfg_we and a handshake occur on the same edge, the write takes effect first and the new weights apply to this step.
- RUN:
  - in_ready=0, cell_en=1.
  - cell_in, cell_ci, cell_prevh and cell_w are held constant.
  - lat_cnt decrements each edge. At the edge where lat_cnt==0, capture in one step:
    - out_h<=cell_hout, out_c<=cell_cout, out_last<=last_q
    - ovf_sticky|=cell_of
    - h_state<=cell_hout, c_state<=cell_cout
    - step_cnt+=1, wrapping modulo 2^CNT_W
    - go to OUT.
  - cell_ci = c_state and cell_prevh = h_state combinationally.
- OUT:
  - out_valid=1; out_* held stable until out_ready.
  - On the out_ready edge, if out_last=1: clear h_state, c_state and step_cnt. Then go to IDLE.
  - out_valid must not drop without a handshake.
- Latency: handshake at edge T0 gives out_valid=1 in the cycle after edge T0+CELL_LAT. Minimum issue interval is CELL_LAT+2 cycles with out_ready tied high.
- cfg_we outside IDLE: no register change; cfg_err=1 for exactly that cycle.
- Async reset mid-RUN or mid-OUT: the in-flight step is discarded, no out_valid, all state returns to reset values.

Decomposition:
- Shared package lstm_pkg holds:
  - register address constants (ADDR_WI..ADDR_BO, ADDR_CTRL, ADDR_CLR)
  - NUM_WREGS=13
  - state enum (IDLE, RUN, OUT)
- Natural sub-module lstm_wreg_file: 13x8 registers plus ctrl, write decode, flat 104-bit cell_w output, cfg_err generation.

Test Plan:
- Reset, then write Wi=0x11 and Bo=0x7F -> cell_w[7:0]=0x11, cell_w[103:96]=0x7F, all other bytes 0, cfg_err never 1.
- CELL_LAT=2, in_data=0x05 accepted at T0, cell model returns Hout=0x30, Cout=0x40 -> cell_en=1 for exactly 2 cycles; out_valid rises after edge T0+2; out_h=0x30, out_c=0x40; next step shows cell_prevh=0x30, cell_ci=0x40.
- 3-sample sequence with in_last on the third, out_ready=1 -> step_cnt reads 1, 2, 3 and then 0 after the third handshake; h_state/c_state=0 before the next sequence's first step.
- out_ready held low 5 cycles in OUT -> out_valid and out_h stable throughout, in_ready=0, a second in_valid is not accepted.
- cfg_we during RUN -> cfg_err pulses one cycle, weights unchanged. Cell returns cell_of=1 -> ovf_sticky=1 until a write to addr 15, after which it is 0.
- rst_n asserted in the 2nd RUN cycle -> out_valid never asserts, in_ready=1 and all outputs 0 immediately.
